// File: rtl/cart_mem_ctrl.sv
// cart_mem_ctrl: turns mapper decode + synchronized MSX strobes into one memory request per bus cycle
// Ports: clk_i/reset_n_i clock and async active-low reset; cart_ena_i, ram_ena_i, rd_n_i, wr_n_i,
// mem_addr_i, cdin_i from mapper/MSX side; cdout_o, busdir_o, wait_n_o back to the MSX bus;
// mreq_o, mwr_o, maddr_o, mwdata_o, mack_i, mrdata_i form the shared memory port;
// timeout_err_o is a sticky flag for any request aborted by the timeout.
module cart_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        cart_ena_i,
    input  logic        ram_ena_i,
    input  logic        rd_n_i,
    input  logic        wr_n_i,
    input  logic [22:0] mem_addr_i,
    input  logic [7:0]  cdin_i,
    output logic [7:0]  cdout_o,
    output logic        busdir_o,
    output logic        wait_n_o,
    output logic        mreq_o,
    output logic        mwr_o,
    output logic [22:0] maddr_o,
    output logic [7:0]  mwdata_o,
    input  logic        mack_i,
    input  logic [7:0]  mrdata_i,
    output logic        timeout_err_o
);
    typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, HOLD} state_e;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    state_e      state_q, state_d;
    logic        rd_sel, wr_sel, req, tmo, done, hold_exit;
    logic [15:0] cnt_q, cnt_d;
    logic [22:0] maddr_q, maddr_d;
    logic [7:0]  mwdata_q, mwdata_d, cdout_q, cdout_d;
    logic        mreq_q, mreq_d, mwr_q, mwr_d, busdir_q, busdir_d;
    logic        wait_n_q, wait_n_d, err_q, err_d, rd_ok_q, rd_ok_d;
    assign rd_sel    = cart_ena_i & ~rd_n_i;
    assign wr_sel    = cart_ena_i & ~wr_n_i;
    assign req       = (state_q == RD_REQ) | (state_q == WR_REQ);
    // mack in the last allowed cycle still wins over the timeout
    assign tmo       = req & ~mack_i & (cnt_q == TMO_LAST);
    assign done      = req & (mack_i | tmo);
    assign hold_exit = ~cart_ena_i | (rd_n_i & wr_n_i);
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:           if (rd_sel) state_d = RD_REQ;
                            else if (wr_sel) state_d = ram_ena_i ? WR_REQ : HOLD;
            RD_REQ, WR_REQ: if (done) state_d = HOLD;
            HOLD:           if (hold_exit) state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end
    always_comb begin
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        mwr_d    = mwr_q;
        cdout_d  = cdout_q;
        wait_n_d = wait_n_q;
        rd_ok_d  = rd_ok_q;
        err_d    = err_q | tmo;
        cnt_d    = req ? cnt_q + 16'd1 : 16'd0;
        mreq_d   = (state_d == RD_REQ) | (state_d == WR_REQ);
        if (state_q == IDLE && (rd_sel || wr_sel)) rd_ok_d = 1'b0;
        if (state_q == IDLE && rd_sel) begin
            maddr_d  = mem_addr_i;
            mwr_d    = 1'b0;
            wait_n_d = 1'b0;
        end else if (state_q == IDLE && wr_sel && ram_ena_i) begin
            maddr_d  = mem_addr_i;
            mwdata_d = cdin_i;
            mwr_d    = 1'b1;
        end
        if (state_q == RD_REQ && done) begin
            cdout_d  = tmo ? 8'hFF : mrdata_i;
            rd_ok_d  = ~tmo;
            wait_n_d = 1'b1;
        end
        // rd_ok_d is 0 on every path into HOLD except a read completed by mack
        busdir_d = (state_d == HOLD) & rd_sel & rd_ok_d;
    end
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q    <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            cdout_q  <= 8'hFF;
            mreq_q   <= 1'b0;
            mwr_q    <= 1'b0;
            busdir_q <= 1'b0;
            wait_n_q <= 1'b1;
            err_q    <= 1'b0;
            rd_ok_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            cdout_q  <= cdout_d;
            mreq_q   <= mreq_d;
            mwr_q    <= mwr_d;
            busdir_q <= busdir_d;
            wait_n_q <= wait_n_d;
            err_q    <= err_d;
            rd_ok_q  <= rd_ok_d;
        end
    end
    assign cdout_o       = cdout_q;
    assign busdir_o      = busdir_q;
    assign wait_n_o      = wait_n_q;
    assign mreq_o        = mreq_q;
    assign mwr_o         = mwr_q;
    assign maddr_o       = maddr_q;
    assign mwdata_o      = mwdata_q;
    assign timeout_err_o = err_q;
endmodule
